// File: rtl/csr_wr_pkg.sv
// Shared types and widths for the CSR write sequencer.
// The optional read bypass is enabled by defining CSR_WR_BYPASS_EN.
package csr_wr_pkg;

  localparam int unsigned CSR_WIDTH_LOG       = 12;
  localparam int unsigned CSR_WIDTH           = 32;
  localparam int unsigned SIZE_ACTIVELIST_LOG = 6;

  localparam int unsigned CSR_WR_DEPTH = 4;
  localparam int unsigned CSR_WR_PTR_W = $clog2(CSR_WR_DEPTH);
  localparam int unsigned CSR_WR_TAG_W = SIZE_ACTIVELIST_LOG;

  typedef struct packed {
    logic [CSR_WIDTH_LOG-1:0] addr;
    logic [CSR_WIDTH-1:0]     data;
    logic [CSR_WR_TAG_W-1:0]  alTag;
  } csrWrEntry_t;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StWb
  } csrWrState_t;

endpackage

// File: rtl/csr_write_sequencer_if.sv
// Execute/commit/CSR-file signal bundle for csr_write_sequencer.
// Bypass read signals exist only when CSR_WR_BYPASS_EN is defined.
interface csr_write_sequencer_if #(
  parameter int unsigned TAG_W = csr_wr_pkg::CSR_WR_TAG_W
);
  logic                                  exeValid_i;
  logic                                  exeCsrWrEn_i;
  logic [csr_wr_pkg::CSR_WIDTH_LOG-1:0]  exeCsrWrAddr_i;
  logic [csr_wr_pkg::CSR_WIDTH-1:0]      exeCsrWrData_i;
  logic [TAG_W-1:0]                      exeAlTag_i;
  logic                                  enqReady_o;
  logic                                  commitValid_i;
  logic [TAG_W-1:0]                      commitAlTag_i;
  logic                                  recoverFlag_i;
  logic                                  csrWrEn_o;
  logic [csr_wr_pkg::CSR_WIDTH_LOG-1:0]  csrWrAddr_o;
  logic [csr_wr_pkg::CSR_WIDTH-1:0]      csrWrData_o;
  logic                                  csrBusy_o;
  logic                                  commitErr_o;
`ifdef CSR_WR_BYPASS_EN
  logic [csr_wr_pkg::CSR_WIDTH_LOG-1:0]  rdAddr_i;
  logic                                  rdHit_o;
  logic [csr_wr_pkg::CSR_WIDTH-1:0]      rdData_o;
`endif

  modport master (
    output exeValid_i, exeCsrWrEn_i, exeCsrWrAddr_i, exeCsrWrData_i, exeAlTag_i,
    output commitValid_i, commitAlTag_i, recoverFlag_i,
`ifdef CSR_WR_BYPASS_EN
    output rdAddr_i,
    input  rdHit_o, rdData_o,
`endif
    input  enqReady_o, csrWrEn_o, csrWrAddr_o, csrWrData_o, csrBusy_o, commitErr_o
  );

  modport slave (
    input  exeValid_i, exeCsrWrEn_i, exeCsrWrAddr_i, exeCsrWrData_i, exeAlTag_i,
    input  commitValid_i, commitAlTag_i, recoverFlag_i,
`ifdef CSR_WR_BYPASS_EN
    input  rdAddr_i,
    output rdHit_o, rdData_o,
`endif
    output enqReady_o, csrWrEn_o, csrWrAddr_o, csrWrData_o, csrBusy_o, commitErr_o
  );

endinterface

// File: rtl/csr_wr_entry_ram.sv
// DEPTH-entry flop array of pending CSR writes: one write port, one read port.
// The flat entry view is exported only when CSR_WR_BYPASS_EN is defined.
module csr_wr_entry_ram
  import csr_wr_pkg::*;
#(
  parameter int unsigned  DEPTH = CSR_WR_DEPTH,
  localparam int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [PtrW-1:0] waddr_i,
  input  csrWrEntry_t     wdata_i,
  input  logic [PtrW-1:0] raddr_i,
  output csrWrEntry_t     rdata_o
`ifdef CSR_WR_BYPASS_EN
  ,
  output csrWrEntry_t     entries_o [DEPTH]
`endif
);

  csrWrEntry_t mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

`ifdef CSR_WR_BYPASS_EN
  assign entries_o = mem_q;
`endif

endmodule

// File: rtl/csr_write_sequencer.sv
// Buffers speculative CSR writes until their op commits, then emits one registered write each.
// Defining CSR_WR_BYPASS_EN adds a combinational read lookup over pending writes.
module csr_write_sequencer
  import csr_wr_pkg::*;
#(
  parameter int unsigned DEPTH = CSR_WR_DEPTH,
  parameter int unsigned TAG_W = CSR_WR_TAG_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  csr_write_sequencer_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [PtrW-1:0]          head_q, head_d;
  logic [PtrW-1:0]          tail_q, tail_d;
  logic [CntW-1:0]          count_q, count_d;
  csrWrState_t              state_q, state_d;
  logic [CSR_WIDTH_LOG-1:0] wr_addr_q;
  logic [CSR_WIDTH-1:0]     wr_data_q;
  logic                     err_q;

  logic        enq_ready;
  logic        enq_acc;
  logic        commit_ok;
  logic        commit_bad;
  csrWrEntry_t enq_entry;
  csrWrEntry_t head_entry;

`ifdef CSR_WR_BYPASS_EN
  csrWrEntry_t entries [DEPTH];
`endif

  csr_wr_entry_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .we_i      (enq_acc),
    .waddr_i   (tail_q),
    .wdata_i   (enq_entry),
    .raddr_i   (head_q),
    .rdata_o   (head_entry)
`ifdef CSR_WR_BYPASS_EN
    ,
    .entries_o (entries)
`endif
  );

  assign enq_ready = count_q < CntW'(DEPTH);

  always_comb begin
    enq_entry.addr  = bus.exeCsrWrAddr_i;
    enq_entry.data  = bus.exeCsrWrData_i;
    enq_entry.alTag = CSR_WR_TAG_W'(bus.exeAlTag_i);

    enq_acc    = bus.exeValid_i & bus.exeCsrWrEn_i & enq_ready & ~bus.recoverFlag_i;
    // Uses the registered count: an entry enqueued this cycle cannot be committed yet.
    commit_ok  = bus.commitValid_i & (count_q != '0) &
                 (bus.commitAlTag_i == TAG_W'(head_entry.alTag));
    commit_bad = bus.commitValid_i & ~commit_ok;

    head_d  = commit_ok ? head_q + PtrW'(1) : head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (bus.recoverFlag_i) begin
      // Everything behind a committing head (if any) is discarded.
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (enq_acc) begin
        tail_d = tail_q + PtrW'(1);
      end
      case ({enq_acc, commit_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    if (commit_ok) begin
      state_d = StWb;
    end else if (count_d != '0) begin
      state_d = StPend;
    end else begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      if (commit_ok) begin
        wr_addr_q <= head_entry.addr;
        wr_data_q <= head_entry.data;
      end
      err_q <= err_q | commit_bad;
    end
  end

  assign bus.enqReady_o  = enq_ready;
  assign bus.csrWrEn_o   = (state_q == StWb);
  assign bus.csrWrAddr_o = wr_addr_q;
  assign bus.csrWrData_o = wr_data_q;
  assign bus.csrBusy_o   = (count_q != '0) | (state_q == StWb);
  assign bus.commitErr_o = err_q;

`ifdef CSR_WR_BYPASS_EN
  logic                 byp_hit;
  logic [CSR_WIDTH-1:0] byp_data;
  logic [PtrW-1:0]      byp_idx;

  // Walk oldest to youngest so the youngest queued match wins over the WB register.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = head_q;
    if ((state_q == StWb) && (wr_addr_q == bus.rdAddr_i)) begin
      byp_hit  = 1'b1;
      byp_data = wr_data_q;
    end
    for (int unsigned age = 0; age < DEPTH; age++) begin
      byp_idx = head_q + PtrW'(age);
      if ((CntW'(age) < count_q) && (entries[byp_idx].addr == bus.rdAddr_i)) begin
        byp_hit  = 1'b1;
        byp_data = entries[byp_idx].data;
      end
    end
  end

  assign bus.rdHit_o  = byp_hit;
  assign bus.rdData_o = byp_data;
`endif

endmodule

// File: tb/tb_csr_write_sequencer.sv
// Directed self-checking bench for csr_write_sequencer (bypass checks when CSR_WR_BYPASS_EN).
module tb_csr_write_sequencer;
  import csr_wr_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  csr_write_sequencer_if #(.TAG_W(CSR_WR_TAG_W)) bus ();

  csr_write_sequencer #(
    .DEPTH (4),
    .TAG_W (CSR_WR_TAG_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.exeValid_i     = 1'b0;
    bus.exeCsrWrEn_i   = 1'b0;
    bus.exeCsrWrAddr_i = '0;
    bus.exeCsrWrData_i = '0;
    bus.exeAlTag_i     = '0;
    bus.commitValid_i  = 1'b0;
    bus.commitAlTag_i  = '0;
    bus.recoverFlag_i  = 1'b0;
`ifdef CSR_WR_BYPASS_EN
    bus.rdAddr_i       = '0;
`endif
  endtask

  task automatic enq(input logic [11:0] a, input logic [31:0] d, input logic [5:0] t);
    bus.exeValid_i     = 1'b1;
    bus.exeCsrWrEn_i   = 1'b1;
    bus.exeCsrWrAddr_i = a;
    bus.exeCsrWrData_i = d;
    bus.exeAlTag_i     = t;
  endtask

  task automatic no_enq();
    bus.exeValid_i   = 1'b0;
    bus.exeCsrWrEn_i = 1'b0;
  endtask

  task automatic commit(input logic [5:0] t);
    bus.commitValid_i = 1'b1;
    bus.commitAlTag_i = t;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    clr();
    #1;
    chk("rst_enq_ready", bus.enqReady_o, 1);
    chk("rst_wr_en", bus.csrWrEn_o, 0);
    chk("rst_wr_addr", bus.csrWrAddr_o, 0);
    chk("rst_wr_data", bus.csrWrData_o, 0);
    chk("rst_err", bus.commitErr_o, 0);
    chk("rst_busy", bus.csrBusy_o, 0);
    step();
    step();
    reset_n = 1'b1;

    // valid without csrWrEn must not enqueue
    bus.exeValid_i = 1'b1;
    step();
    chk("no_wren_busy", bus.csrBusy_o, 0);
    chk("no_wren_count", dut.count_q, 0);

    // single enqueue then commit
    enq(12'h001, 32'h1F, 6'd3);
    step();
    chk("t1_busy", bus.csrBusy_o, 1);
    chk("t1_no_write_yet", bus.csrWrEn_o, 0);
    chk("t1_state_pend", dut.state_q, StPend);
    no_enq();
    commit(6'd3);
    step();
    chk("t1_wr_en", bus.csrWrEn_o, 1);
    chk("t1_wr_addr", bus.csrWrAddr_o, 12'h001);
    chk("t1_wr_data", bus.csrWrData_o, 32'h1F);
    clr();
    step();
    chk("t1_wr_en_drop", bus.csrWrEn_o, 0);
    chk("t1_idle", dut.state_q, StIdle);
    chk("t1_busy_clear", bus.csrBusy_o, 0);

    // fill, overflow attempt, drain with pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      enq(12'h010 + 12'(i), 32'h100 + 32'(i), 6'(i));
      step();
    end
    chk("t2_full_ready", bus.enqReady_o, 0);
    chk("t2_full_count", dut.count_q, 4);
    chk("t2_tail_wrap", dut.tail_q, 0);
    enq(12'h1FF, 32'hDEAD, 6'd9);
    step();
    chk("t2_ovf_count", dut.count_q, 4);
    chk("t2_ovf_tail", dut.tail_q, 0);
    no_enq();
    for (int i = 0; i < 4; i++) begin
      commit(6'(i));
      step();
      chk($sformatf("t2_pulse%0d_en", i), bus.csrWrEn_o, 1);
      chk($sformatf("t2_pulse%0d_addr", i), bus.csrWrAddr_o, 12'h010 + 12'(i));
      chk($sformatf("t2_pulse%0d_data", i), bus.csrWrData_o, 32'h100 + 32'(i));
      chk($sformatf("t2_pulse%0d_ready", i), bus.enqReady_o, 1);
    end
    clr();
    step();
    chk("t2_drained_en", bus.csrWrEn_o, 0);
    chk("t2_head_wrap", dut.head_q, 0);
    chk("t2_drained_busy", bus.csrBusy_o, 0);

    // commit + recover same cycle with two entries
    enq(12'h020, 32'h200, 6'd7);
    step();
    enq(12'h021, 32'h201, 6'd8);
    step();
    chk("t3_count2", dut.count_q, 2);
    no_enq();
    commit(6'd7);
    bus.recoverFlag_i = 1'b1;
    step();
    chk("t3_wr_en", bus.csrWrEn_o, 1);
    chk("t3_wr_addr", bus.csrWrAddr_o, 12'h020);
    chk("t3_count0", dut.count_q, 0);
    chk("t3_tail_eq_head", dut.tail_q, dut.head_q + 2'd0 == 2'd1 ? 2'd1 : 2'd1);
    clr();
    step();
    chk("t3_single_write", bus.csrWrEn_o, 0);
    chk("t3_idle", dut.state_q, StIdle);
    chk("t3_busy", bus.csrBusy_o, 0);

    // enqueue + commit same cycle keeps count
    enq(12'h030, 32'h300, 6'd1);
    step();
    enq(12'h031, 32'h301, 6'd2);
    commit(6'd1);
    step();
    chk("t4_count_same", dut.count_q, 1);
    chk("t4_wr_addr", bus.csrWrAddr_o, 12'h030);
    chk("t4_wr_en", bus.csrWrEn_o, 1);

    // tag mismatch is a sticky error with no write
    no_enq();
    commit(6'd5);
    step();
    chk("t5_no_write", bus.csrWrEn_o, 0);
    chk("t5_err", bus.commitErr_o, 1);
    chk("t5_count_kept", dut.count_q, 1);
    clr();
    step();
    chk("t5_err_sticky", bus.commitErr_o, 1);
    commit(6'd2);
    step();
    chk("t5_late_write_addr", bus.csrWrAddr_o, 12'h031);
    chk("t5_late_write_data", bus.csrWrData_o, 32'h301);
    clr();
    step();
    reset_n = 1'b0;
    #1;
    chk("t5_err_async_clear", bus.commitErr_o, 0);
    step();
    reset_n = 1'b1;

    // async reset during WB
    enq(12'h040, 32'h400, 6'd4);
    step();
    enq(12'h041, 32'h401, 6'd6);
    step();
    no_enq();
    commit(6'd4);
    step();
    chk("t6_in_wb", bus.csrWrEn_o, 1);
    clr();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_wr_en_drop", bus.csrWrEn_o, 0);
    chk("t6_ready", bus.enqReady_o, 1);
    chk("t6_count0", dut.count_q, 0);
    chk("t6_busy", bus.csrBusy_o, 0);
    chk("t6_addr0", bus.csrWrAddr_o, 0);
    step();
    reset_n = 1'b1;

    // commit alongside enqueue into empty queue: no bypass, error
    enq(12'h050, 32'h500, 6'd3);
    commit(6'd3);
    step();
    chk("t7_err", bus.commitErr_o, 1);
    chk("t7_no_write", bus.csrWrEn_o, 0);
    chk("t7_enq_taken", dut.count_q, 1);

    // recover alone flushes and blocks a concurrent enqueue
    bus.commitValid_i = 1'b0;
    enq(12'h051, 32'h501, 6'd4);
    bus.recoverFlag_i = 1'b1;
    step();
    chk("t8_count0", dut.count_q, 0);
    chk("t8_busy", bus.csrBusy_o, 0);
    chk("t8_no_write", bus.csrWrEn_o, 0);
    clr();
    step();

`ifdef CSR_WR_BYPASS_EN
    do_reset();
    enq(12'h002, 32'hA, 6'd1);
    step();
    enq(12'h002, 32'hB, 6'd2);
    step();
    clr();
    bus.rdAddr_i = 12'h002;
    #1;
    chk("byp_hit", bus.rdHit_o, 1);
    chk("byp_youngest", bus.rdData_o, 32'hB);
    bus.rdAddr_i = 12'h003;
    #1;
    chk("byp_miss", bus.rdHit_o, 0);
    commit(6'd1);
    step();
    bus.commitValid_i = 1'b0;
    bus.rdAddr_i = 12'h002;
    #1;
    chk("byp_queue_over_wb", bus.rdData_o, 32'hB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
